// File: rtl/yrv_uart_pkg.sv
// Shared UART types: transmitter FSM state encoding and the baud divisor helper.
// The PARITY state exists only when AUX_UART_TX_PARITY_EN is defined.
package yrv_uart_pkg;

`ifdef AUX_UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_e;
`else
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_tx_state_e;
`endif

   // Clock cycles per serial bit, rounded down.
   function automatic int baud_divisor(input int clk_frequency, input int baud_rate);
      return clk_frequency / baud_rate;
   endfunction

endpackage

// File: rtl/aux_uart_tx_fifo.sv
// Synchronous byte FIFO feeding the aux UART transmitter.
// DEPTH must be a power of two so the pointers wrap naturally.
module aux_uart_tx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic [7:0]                 push_data,
   input  logic                       pop,
   output logic [7:0]                 pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
      $error("aux_uart_tx_fifo: DEPTH must be a power of two in 2..16");
   end

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; only slots between the pointers are ever read as valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/aux_uart_tx.sv
// Buffered 8N1 UART transmitter for the aux serial port, LSB first, idle high.
// Define AUX_UART_TX_PARITY_EN to insert an even parity bit after the data bits.
module aux_uart_tx #(
   parameter int CLK_FREQUENCY = 50000000,
   parameter int BAUD_RATE     = 115200,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   import yrv_uart_pkg::*;

   localparam int DIV = baud_divisor(CLK_FREQUENCY, BAUD_RATE);
   localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

   if (DIV < 2) begin : g_div_check
      $error("aux_uart_tx: CLK_FREQUENCY / BAUD_RATE must be at least 2");
   end

   uart_tx_state_e state_q, state_d;
   logic [CW-1:0]  baud_q, baud_d;
   logic [2:0]     bit_q, bit_d;
   logic [7:0]     shift_q, shift_d;
   logic           tx_q, tx_d;
   logic           pop;
   logic           push;
   logic           fifo_empty;
   logic           fifo_full;
   logic [7:0]     head;
   logic           baud_done;
`ifdef AUX_UART_TX_PARITY_EN
   logic           parity_q, parity_d;
`endif

   assign push      = tx_valid && tx_ready;
   assign tx_ready  = !fifo_full;
   assign baud_done = (baud_q == BAUD_LAST);
   assign busy      = (state_q != IDLE) || !fifo_empty;
   assign tx        = tx_q;

   aux_uart_tx_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (push),
      .push_data(tx_data),
      .pop      (pop),
      .pop_data (head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
`ifdef AUX_UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
`ifdef AUX_UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // The line level is derived from the next state so tx leaves a flop aligned with the FSM.
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      pop      = 1'b0;
      tx_d     = 1'b1;
`ifdef AUX_UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop      = 1'b1;
               state_d  = START;
               baud_d   = '0;
               bit_d    = '0;
               shift_d  = head;
`ifdef AUX_UART_TX_PARITY_EN
               parity_d = ^head;
`endif
            end
         end
         START: begin
            if (baud_done) begin
               baud_d  = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
`ifdef AUX_UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
`ifdef AUX_UART_TX_PARITY_EN
         PARITY: begin
            if (baud_done) begin
               baud_d  = '0;
               state_d = STOP;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
`endif
         STOP: begin
            if (baud_done) begin
               baud_d = '0;
               // Chain straight into the next start bit so queued frames have no idle gap.
               if (!fifo_empty) begin
                  pop      = 1'b1;
                  state_d  = START;
                  bit_d    = '0;
                  shift_d  = head;
`ifdef AUX_UART_TX_PARITY_EN
                  parity_d = ^head;
`endif
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
`ifdef AUX_UART_TX_PARITY_EN
         PARITY:  tx_d = parity_d;
`endif
         default: tx_d = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_aux_uart_tx.sv
// Directed self-checking bench for aux_uart_tx at 1 MHz / 100 kbaud (10 clocks per bit).
// Frame length follows AUX_UART_TX_PARITY_EN when it is defined for the build.
module tb_aux_uart_tx;

   localparam int DIV = 10;
`ifdef AUX_UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME_CYCLES = FRAME_BITS * DIV;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       tx;
   logic       busy;
   logic [2:0] fifo_count;

   int checks = 0;
   int passed = 0;

   aux_uart_tx #(
      .CLK_FREQUENCY(1000000),
      .BAUD_RATE    (100000),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx        (tx),
      .busy      (busy),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   // Expected line level for bit slot k of a frame carrying byte b.
   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
`ifdef AUX_UART_TX_PARITY_EN
      if (k == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   // Entered #1 after the edge that pops b; leaves #1 after the edge ending its stop bit.
   task automatic check_frame(input logic [7:0] b, input string name);
      for (int k = 0; k < FRAME_BITS; k++) begin
         logic exp_bit;
         logic got;
         int   bad;
         exp_bit = frame_bit(b, k);
         got     = exp_bit;
         bad     = 0;
         for (int c = 0; c < DIV; c++) begin
            if ((tx !== exp_bit) && (bad == 0)) begin
               bad = 1;
               got = tx;
            end
            @(posedge clk);
            #1;
         end
         checks++;
         if (bad != 0)
            $display("[TB] FAIL %s slot %0d: tx=%b expected %b", name, k, got, exp_bit);
         else
            passed++;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b1;
      #2;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (tx !== 1'b1) $display("[TB] FAIL reset_tx: got %b expected 1", tx); else passed++;
      checks++; if (tx_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", tx_ready); else passed++;
      checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
      checks++; if (fifo_count !== 3'd0) $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count); else passed++;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single(input logic [7:0] b, input string name);
      tx_data  = b;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      checks++; if (fifo_count !== 3'd1) $display("[TB] FAIL %s_count_after_push: got %0d expected 1", name, fifo_count); else passed++;
      checks++; if (tx !== 1'b1) $display("[TB] FAIL %s_tx_before_start: got %b expected 1", name, tx); else passed++;
      checks++; if (busy !== 1'b1) $display("[TB] FAIL %s_busy_queued: got %b expected 1", name, busy); else passed++;
      @(posedge clk);
      #1;
      check_frame(b, name);
      checks++; if (tx !== 1'b1) $display("[TB] FAIL %s_tx_after: got %b expected 1", name, tx); else passed++;
      checks++; if (busy !== 1'b0) $display("[TB] FAIL %s_busy_after: got %b expected 0", name, busy); else passed++;
      checks++; if (fifo_count !== 3'd0) $display("[TB] FAIL %s_count_after: got %0d expected 0", name, fifo_count); else passed++;
   endtask

   task automatic test_back_to_back();
      int acc[1:6];
      foreach (acc[i]) acc[i] = -1;
      fork
         begin : producer
            int  e;
            int  idx;
            logic rdy;
            e   = 0;
            idx = 1;
            tx_data  = 8'h01;
            tx_valid = 1'b1;
            while ((idx <= 6) && (e < 400)) begin
               rdy = tx_ready;
               @(posedge clk);
               #1;
               if (rdy) begin
                  acc[idx] = e;
                  idx++;
                  if (idx <= 6) tx_data = 8'(idx);
                  else          tx_valid = 1'b0;
               end
               if (e == 4) begin
                  checks++; if (tx_ready !== 1'b0) $display("[TB] FAIL b2b_ready_full: got %b expected 0", tx_ready); else passed++;
                  checks++; if (fifo_count !== 3'd4) $display("[TB] FAIL b2b_count_full: got %0d expected 4", fifo_count); else passed++;
               end
               e++;
            end
            tx_valid = 1'b0;
            checks++; if (idx != 7) $display("[TB] FAIL b2b_accept_timeout: accepted %0d expected 6", idx - 1); else passed++;
            for (int i = 1; i <= 5; i++) begin
               checks++;
               if (acc[i] != i - 1) $display("[TB] FAIL b2b_accept_edge_%0d: got %0d expected %0d", i, acc[i], i - 1);
               else passed++;
            end
            checks++;
            if (acc[6] != FRAME_CYCLES + 2) $display("[TB] FAIL b2b_accept_edge_6: got %0d expected %0d", acc[6], FRAME_CYCLES + 2);
            else passed++;
         end
         begin : monitor
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            for (int i = 1; i <= 6; i++) check_frame(8'(i), $sformatf("b2b_frame%0d", i));
         end
      join
      checks++; if (tx !== 1'b1) $display("[TB] FAIL b2b_tx_after: got %b expected 1", tx); else passed++;
      checks++; if (busy !== 1'b0) $display("[TB] FAIL b2b_busy_after: got %b expected 0", busy); else passed++;
   endtask

   task automatic test_reset_mid_frame();
      int bad;
      tx_data  = 8'hA3;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_data = 8'h11;
      @(posedge clk);
      #1;
      tx_data = 8'h22;
      @(posedge clk);
      #1;
      tx_data = 8'h33;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      checks++; if (fifo_count !== 3'd3) $display("[TB] FAIL abort_queued: got %0d expected 3", fifo_count); else passed++;
      repeat (43) @(posedge clk);
      #1;
      // Cycle 45 of the frame is data bit 3 of 0xA3, which is 0.
      checks++; if (tx !== 1'b0) $display("[TB] FAIL abort_tx_before: got %b expected 0", tx); else passed++;
      reset_n = 1'b0;
      #1;
      checks++; if (tx !== 1'b1) $display("[TB] FAIL abort_tx_reset: got %b expected 1", tx); else passed++;
      checks++; if (fifo_count !== 3'd0) $display("[TB] FAIL abort_count: got %0d expected 0", fifo_count); else passed++;
      checks++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b expected 0", busy); else passed++;
      checks++; if (tx_ready !== 1'b1) $display("[TB] FAIL abort_ready: got %b expected 1", tx_ready); else passed++;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      bad = 0;
      for (int c = 0; c < 150; c++) begin
         @(posedge clk);
         #1;
         if ((tx !== 1'b1) || (busy !== 1'b0)) bad++;
      end
      checks++;
      if (bad != 0) $display("[TB] FAIL abort_quiet: got %0d active cycles expected 0", bad);
      else passed++;
   endtask

`ifdef AUX_UART_TX_PARITY_EN
   task automatic test_parity();
      test_single(8'h07, "parity_07");
      test_single(8'h03, "parity_03");
   endtask
`endif

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_single(8'h55, "single_55");
      test_back_to_back();
      test_reset_mid_frame();
`ifdef AUX_UART_TX_PARITY_EN
      test_parity();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/aux_uart_tx.md
AUX_UART_TX -- requirements
Module: aux_uart_tx

Interface
REQ-001 Parameter CLK_FREQUENCY, default 50000000, clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate.
REQ-003 Parameter FIFO_DEPTH, default 4, byte buffer depth; power of two, 2..16.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 tx_data  input  8  byte to send.
REQ-007 tx_valid  input  1  tx_data is valid.
REQ-008 tx_ready  output  1  buffer can accept a byte; high when FIFO not full.
REQ-009 tx  output  1  serial line, idle high, 8N1 LSB first.
REQ-010 busy  output  1  frame in progress or FIFO not empty.
REQ-011 fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered.

Function
REQ-012 DIV = CLK_FREQUENCY / BAUD_RATE, integer floor; each serial bit lasts exactly DIV clk cycles; DIV < 2 is an elaboration error.
REQ-013 A byte is accepted on an edge where tx_valid and tx_ready are both high; tx_ready is combinational from FIFO state only, never from tx_valid.
REQ-014 Full FIFO: tx_ready low; a pop on that edge frees a slot for the next cycle only (no same-cycle push-through).
REQ-015 FSM states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-016 IDLE -> START on edge where FIFO non-empty: pop head into shift register, clear baud counter, bit index = 0.
REQ-017 START: tx = 0 for DIV cycles -> DATA.
REQ-018 DATA: tx = shift[0], shift right every DIV cycles; after bit index 7 -> PARITY if enabled, else STOP.
REQ-019 STOP: tx = 1 for DIV cycles; then START with pop if FIFO non-empty (no idle cycle between frames), else IDLE.
REQ-020 Latency: byte pushed into empty FIFO with FSM in IDLE at edge N; tx falls after edge N+1.
REQ-021 tx is driven from a flop, glitch-free.
REQ-022 Baud counter counts 0..DIV-1 and wraps; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-023 Simultaneous push and pop leave fifo_count unchanged.

Reset
REQ-024 reset_n low, asynchronously: tx = 1, FSM = IDLE, fifo_count = 0, tx_ready = 1, busy = 0, counters cleared.
REQ-025 Reset mid-frame aborts the frame and discards all buffered bytes; line returns high immediately.

Configuration
REQ-026 Macro AUX_UART_TX_PARITY_EN defined: PARITY state inserted after DATA, tx = XOR of the 8 data bits (even parity) for DIV cycles; frame = 11*DIV cycles.
REQ-027 Macro undefined: no PARITY state or logic; frame = 10*DIV cycles.

Structure
REQ-028 Package yrv_uart_pkg holds the FSM state enum and a constant function computing DIV from CLK_FREQUENCY and BAUD_RATE.
REQ-029 Sub-module aux_uart_tx_fifo: synchronous byte FIFO, push/pop/full/empty/count, same clock and reset.
REQ-030 Top-level integration places aux_uart_tx beside the aux UART receive pin, sharing clk and reset_n.

Verification (CLK_FREQUENCY=1000000, BAUD_RATE=100000, DIV=10)
REQ-031 Reset: hold reset_n low 3 cycles -> tx=1, tx_ready=1, busy=0, fifo_count=0.
REQ-032 Push 0x55 at edge N -> tx low after edge N+1 for 10 cycles, then bits 1,0,1,0,1,0,1,0 each 10 cycles, stop high 10 cycles, busy low after 100 cycles.
REQ-033 tx_valid held high with bytes 0x01..0x06 from edge 0 -> 0x01..0x05 accepted on edges 0..4, tx_ready low after edge 4 and high again after the pop at frame boundary; frames contiguous, no idle gap.
REQ-034 Assert reset_n low at cycle 45 of a 0xA3 frame with 3 bytes queued -> tx=1 same cycle, fifo_count=0, no further frames after release.
REQ-035 AUX_UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1 after bit 7, frame length 110 cycles; 0x03 -> parity bit 0.
